// File: rtl/mem_arb_pkg.sv
// Shared definitions for the cache-side memory port arbiter and its requesters.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Opcodes shared with l1d/l1i/ptw/prefetcher.
    localparam logic [3:0] OP_LOAD     = 4'h0;
    localparam logic [3:0] OP_STORE    = 4'h1;
    localparam logic [3:0] OP_PTW_LOAD = 4'h2;
    localparam logic [3:0] OP_PREFETCH = 4'h3;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request bit at or after ptr_i, wrapping.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 any_o
);
    // Padding to a power of two keeps index widths exact for any port count.
    localparam int P = 1 << IDX_W;

    logic [P-1:0]     req_pad;
    logic [P-1:0]     gnt_pad;
    logic [IDX_W-1:0] p;

    always_comb begin
        req_pad = P'(req_i);
        gnt_pad = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        p       = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            p = IDX_W'((int'(ptr_i) + k) % NUM_PORTS);
            if (!any_o && req_pad[p]) begin
                gnt_pad[p] = 1'b1;
                idx_o      = p;
                any_o      = 1'b1;
            end
        end
    end

    assign gnt_o = gnt_pad[NUM_PORTS-1:0];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter of N cache requesters onto one cache-line memory port,
// one transaction outstanding, with a sticky watchdog flag.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_W         = 32,
    parameter int CL_BITS        = 128,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W         = idx_w(NUM_PORTS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           port_req_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0]    port_req_addr,
    input  logic [NUM_PORTS*4-1:0]         port_req_opcode,
    input  logic [NUM_PORTS*CL_BITS-1:0]   port_req_store_data,
    output logic [NUM_PORTS-1:0]           port_req_ack,
    output logic [NUM_PORTS-1:0]           port_rsp_valid,
    output logic                           mem_req_valid,
    output logic [ADDR_W-1:0]              mem_req_addr,
    output logic [3:0]                     mem_req_opcode,
    output logic [CL_BITS-1:0]             mem_req_store_data,
    input  logic                           mem_rsp_valid,
    output logic [IDX_W-1:0]               grant_idx,
    output logic                           busy,
    output logic                           timeout_err
);
    localparam int WD_W = idx_w(TIMEOUT_CYCLES + 1);

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0]   pending_q, pending_d;
    logic [NUM_PORTS-1:0]   ack_q, ack_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   timeout_q, timeout_d;

    logic [NUM_PORTS-1:0]   cand;
    logic [NUM_PORTS-1:0]   pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;

    assign cand = pending_q | port_req_valid;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req_i (cand),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_ptr_d       = rr_ptr_q;
        pending_d      = cand;
        ack_d          = '0;
        wd_d           = wd_q;
        timeout_d      = timeout_q;
        port_rsp_valid = '0;
        case (state_q)
            IDLE: begin
                // A request pulse arriving in the grant cycle is consumed here.
                if (pick_any) begin
                    state_d   = BUSY;
                    grant_d   = pick_idx;
                    pending_d = cand & ~pick_gnt;
                    ack_d     = pick_gnt;
                    wd_d      = '0;
                end
            end
            BUSY: begin
                if (wd_q != WD_W'(TIMEOUT_CYCLES))
                    wd_d = wd_q + 1'b1;
                if (TIMEOUT_CYCLES != 0 && wd_d == WD_W'(TIMEOUT_CYCLES))
                    timeout_d = 1'b1;
                if (mem_rsp_valid) begin
                    port_rsp_valid = NUM_PORTS'(1) << grant_q;
                    state_d        = IDLE;
                    rr_ptr_d       = IDX_W'((int'(grant_q) + 1) % NUM_PORTS);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            pending_q <= '0;
            ack_q     <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    // Requesters hold their fields until their response, so a live mux is safe.
    assign mem_req_addr       = port_req_addr[int'(grant_q)*ADDR_W +: ADDR_W];
    assign mem_req_opcode     = port_req_opcode[int'(grant_q)*4 +: 4];
    assign mem_req_store_data = port_req_store_data[int'(grant_q)*CL_BITS +: CL_BITS];

    assign mem_req_valid = (state_q == BUSY);
    assign busy          = (state_q == BUSY);
    assign port_req_ack  = ack_q;
    assign grant_idx     = grant_q;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a set-based round-robin model predicts grants and responses.
module tb_mem_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int CW = 64;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [N-1:0]    req_v;
    logic [N*AW-1:0] req_a;
    logic [N*4-1:0]  req_o;
    logic [N*CW-1:0] req_d;
    logic [N-1:0]    ack, rspv;
    logic            mvalid, mrsp, busy, terr;
    logic [AW-1:0]   maddr;
    logic [3:0]      mop;
    logic [CW-1:0]   mdata;
    logic [1:0]      gidx;

    logic            v1, ack1, rspv1, mvalid1, mrsp1, busy1, terr1;
    logic [AW-1:0]   a1, maddr1;
    logic [3:0]      o1, mop1;
    logic [CW-1:0]   d1, mdata1;
    logic [0:0]      gidx1;

    mem_port_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .CL_BITS(CW), .TIMEOUT_CYCLES(TO)) u4 (
        .clk(clk), .reset(reset),
        .port_req_valid(req_v), .port_req_addr(req_a), .port_req_opcode(req_o),
        .port_req_store_data(req_d), .port_req_ack(ack), .port_rsp_valid(rspv),
        .mem_req_valid(mvalid), .mem_req_addr(maddr), .mem_req_opcode(mop),
        .mem_req_store_data(mdata), .mem_rsp_valid(mrsp), .grant_idx(gidx),
        .busy(busy), .timeout_err(terr));

    mem_port_arbiter #(.NUM_PORTS(1), .ADDR_W(AW), .CL_BITS(CW), .TIMEOUT_CYCLES(0)) u1 (
        .clk(clk), .reset(reset),
        .port_req_valid(v1), .port_req_addr(a1), .port_req_opcode(o1),
        .port_req_store_data(d1), .port_req_ack(ack1), .port_rsp_valid(rspv1),
        .mem_req_valid(mvalid1), .mem_req_addr(maddr1), .mem_req_opcode(mop1),
        .mem_req_store_data(mdata1), .mem_rsp_valid(mrsp1), .grant_idx(gidx1),
        .busy(busy1), .timeout_err(terr1));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    typedef struct {
        int            port;
        logic [AW-1:0] a;
        logic [3:0]    op;
        logic [CW-1:0] d;
    } gnt_t;

    gnt_t gq[$];
    int   rq[$];

    // Reference model: set of waiting ports, rotation pointer, one outstanding.
    bit            m_busy, cur_busy;
    logic [N-1:0]  m_pend, outst;
    int            m_ptr, m_gnt, dly;
    logic [AW-1:0] ha[N];
    logic [3:0]    ho[N];
    logic [CW-1:0] hd[N];
    bit            use_ovr;
    logic [AW-1:0] ovr_addr;

    task automatic cycle(input logic [N-1:0] v, input bit rsp);
        logic [N-1:0] cand;
        int p;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                ha[i] = use_ovr ? ovr_addr : AW'($urandom);
                ho[i] = 4'($urandom);
                hd[i] = {$urandom, $urandom};
                outst[i] = 1'b1;
            end
            req_a[i*AW +: AW] = ha[i];
            req_o[i*4 +: 4]   = ho[i];
            req_d[i*CW +: CW] = hd[i];
        end
        req_v = v;
        mrsp  = rsp;
        cur_busy = m_busy;
        if (!m_busy) begin
            cand = m_pend | v;
            m_pend = cand;
            for (int k = 0; k < N; k++) begin
                p = (m_ptr + k) % N;
                if (cand[p]) begin
                    gq.push_back('{p, ha[p], ho[p], hd[p]});
                    m_pend[p] = 1'b0;
                    m_busy = 1'b1;
                    m_gnt = p;
                    dly = $urandom_range(0, 4);
                    break;
                end
            end
        end else begin
            m_pend |= v;
            if (rsp) begin
                rq.push_back(m_gnt);
                outst[m_gnt] = 1'b0;
                m_busy = 1'b0;
                m_ptr = (m_gnt + 1) % N;
            end
        end
    endtask

    task automatic auto_rsp(output bit r);
        if (m_busy) begin
            r = (dly == 0);
            if (dly != 0) dly--;
        end else begin
            r = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_v = '0;
        mrsp = 1'b0;
        m_busy = 0; cur_busy = 0; m_pend = '0; m_ptr = 0; outst = '0;
        gq.delete(); rq.delete();
        #1;
        chk("rst_mem_req_valid", mvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_timeout_err", terr, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : monitor
        gnt_t e;
        int   p;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                chk("mem_req_valid", mvalid, cur_busy);
                if (ack !== '0) begin
                    if (gq.size() == 0) chk("unexpected_ack", ack, 0);
                    else begin
                        e = gq.pop_front();
                        chk("ack_onehot", ack, 64'(1) << e.port);
                        chk("grant_idx", gidx, e.port);
                        chk("mem_req_addr", maddr, e.a);
                        chk("mem_req_opcode", mop, e.op);
                        chk("mem_req_store_data", mdata, e.d);
                    end
                end
                if (rspv !== '0) begin
                    if (rq.size() == 0) chk("unexpected_rsp", rspv, 0);
                    else begin
                        p = rq.pop_front();
                        chk("port_rsp_valid", rspv, 64'(1) << p);
                    end
                end
            end
        end
    end

    initial begin : stim
        bit r;
        logic [N-1:0] v;
        req_v = '0; mrsp = 1'b0; use_ovr = 0; ovr_addr = '0;
        m_busy = 0; cur_busy = 0; m_pend = '0; m_ptr = 0; m_gnt = 0; dly = 0; outst = '0;
        for (int i = 0; i < N; i++) begin
            ha[i] = AW'($urandom); ho[i] = 4'($urandom); hd[i] = {$urandom, $urandom};
            req_a[i*AW +: AW] = ha[i]; req_o[i*4 +: 4] = ho[i]; req_d[i*CW +: CW] = hd[i];
        end
        v1 = 0; mrsp1 = 0; a1 = '0; o1 = '0; d1 = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req_valid", mvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_rsp", rspv, 0);
        chk("rst_grant_idx", gidx, 0);
        chk("rst_timeout_err", terr, 0);
        chk("rst_addr_port0", maddr, ha[0]);
        chk("rst_data_port0", mdata, hd[0]);
        @(negedge clk);
        reset = 1'b0;

        // Lone request from port 1, response five cycles later.
        use_ovr = 1; ovr_addr = 32'h1000;
        cycle(4'b0010, 0);
        use_ovr = 0;
        cycle(0, 0); #1;
        chk("t1_ack", ack, 4'b0010);
        chk("t1_valid", mvalid, 1);
        chk("t1_addr", maddr, 32'h1000);
        repeat (3) cycle(0, 0);
        cycle(0, 1); #1;
        chk("t1_rsp", rspv, 4'b0010);
        cycle(0, 0); #1;
        chk("t1_valid_low", mvalid, 0);

        // All four at once: strict rotation 0,1,2,3.
        do_reset();
        cycle(4'b1111, 0);
        for (int g = 0; g < N; g++) begin
            cycle(0, 0); #1;
            chk("t2_order", gidx, g);
            repeat (2) cycle(0, 0);
            cycle(0, 1);
            cycle(0, 0);
        end

        // Port 2 in flight, ports 0 and 3 arrive: 3 must precede 0.
        do_reset();
        cycle(4'b0100, 0);
        cycle(0, 0);
        cycle(4'b1001, 0);
        cycle(0, 1);
        cycle(0, 0);
        cycle(0, 0); #1;
        chk("t3_next3", gidx, 3);
        cycle(0, 1);
        cycle(0, 0);
        cycle(0, 0); #1;
        chk("t3_next0", gidx, 0);
        cycle(0, 1);
        cycle(0, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            v = 4'($urandom) & 4'($urandom) & ~outst;
            auto_rsp(r);
            cycle(v, r);
        end
        for (int n = 0; n < 80 && (m_busy || m_pend != '0); n++) begin
            auto_rsp(r);
            cycle(0, r);
        end
        repeat (2) cycle(0, 0);
        chk("rand_grants_drained", gq.size(), 0);
        chk("rand_rsps_drained", rq.size(), 0);
        chk("rand_no_timeout", terr, 0);

        // Watchdog: no response, flag after 8 busy cycles, sticky.
        do_reset();
        cycle(4'b0001, 0);
        for (int k = 1; k <= 8; k++) cycle(0, 0);
        #1;
        chk("wd_low_at_8", terr, 0);
        cycle(0, 0); #1;
        chk("wd_high_at_9", terr, 1);
        cycle(0, 1);
        repeat (3) cycle(0, 0);
        #1;
        chk("wd_sticky", terr, 1);
        chk("wd_idle_after_rsp", mvalid, 0);

        // Reset two cycles into a transaction with port 3 pending.
        do_reset();
        cycle(4'b0100, 0);
        cycle(0, 0);
        cycle(4'b1000, 0);
        @(negedge clk);
        reset = 1'b1;
        req_v = '0; mrsp = 1'b0;
        m_busy = 0; cur_busy = 0; m_pend = '0; m_ptr = 0; outst = '0;
        gq.delete(); rq.delete();
        #1;
        chk("midrst_valid", mvalid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ack", ack, 0);
        @(negedge clk);
        reset = 1'b0;
        cycle(0, 1);
        repeat (3) cycle(0, 0);
        #1;
        chk("midrst_pending_dropped", mvalid, 0);
        chk("midrst_timeout", terr, 0);

        // Single-port instance: back-to-back requests with one idle gap.
        repeat (2) cycle(0, 0);
        @(negedge clk); a1 = AW'($urandom); o1 = 4'($urandom); d1 = {$urandom, $urandom}; v1 = 1;
        @(negedge clk); v1 = 0; #1;
        chk("n1_ack", ack1, 1);
        chk("n1_valid", mvalid1, 1);
        chk("n1_grant", gidx1, 0);
        chk("n1_addr", maddr1, a1);
        @(negedge clk); v1 = 1; mrsp1 = 1; #1;
        chk("n1_rsp", rspv1, 1);
        @(negedge clk); v1 = 0; mrsp1 = 0; #1;
        chk("n1_gap", mvalid1, 0);
        @(negedge clk); #1;
        chk("n1_ack2", ack1, 1);
        chk("n1_valid2", mvalid1, 1);
        chk("n1_grant2", gidx1, 0);
        @(negedge clk); mrsp1 = 1; #1;
        chk("n1_rsp2", rspv1, 1);
        @(negedge clk); mrsp1 = 0; #1;
        chk("n1_idle", mvalid1, 0);
        @(negedge clk); #1;
        chk("n1_no_extra", mvalid1, 0);

        chk("final_grants", gq.size(), 0);
        chk("final_rsps", rq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised round-robin arbiter between N cache-side memory requesters (L1D, L1I, PTW, prefetcher, …) and the single cache-line memory port, replacing the fixed two-way L1D/L1I arbiter in the core top level. Pending requests are latched, one transaction is outstanding at a time, and the response is routed to the granted port. Adds rotating fairness over any port count, a store-data mux from the granted port, and a watchdog timeout flag.

## Interface
- NUM_PORTS, 2: requester count, ≥1; port 0 = L1D, port 1 = L1I.
- ADDR_W, `M_WIDTH: request address width.
- CL_BITS, 1<<(`LG_L1D_CL_LEN+3): cache-line data width.
- TIMEOUT_CYCLES, 1024: busy cycles before timeout_err; 0 disables.
- IDX_W: derived, max(1,$clog2(NUM_PORTS)).
- Clock/reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- port_req_valid  in  NUM_PORTS  one-cycle request pulse per port.
- port_req_addr  in  NUM_PORTS*ADDR_W  flattened; port i at [i*ADDR_W +: ADDR_W].
- port_req_opcode  in  NUM_PORTS*4  flattened opcodes.
- port_req_store_data  in  NUM_PORTS*CL_BITS  flattened store lines.
- port_req_ack  out  NUM_PORTS  one-hot pulse: request granted.
- port_rsp_valid  out  NUM_PORTS  one-hot pulse: response for that port.
- mem_req_valid  out  1  held high for whole transaction.
- mem_req_addr  out  ADDR_W  granted port's address.
- mem_req_opcode  out  4  granted port's opcode.
- mem_req_store_data  out  CL_BITS  granted port's store line.
- mem_rsp_valid  in  1  response pulse from memory.
- grant_idx  out  IDX_W  currently/last granted port.
- busy  out  1  transaction outstanding.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- pending[i]: set on port_req_valid[i], cleared when port i granted; n_pending = (pending | port_req_valid) & ~grant_onehot (valid pulse in grant cycle is consumed).
- States (arb_state_t): IDLE, BUSY.
- IDLE: cand = pending | port_req_valid; if nonzero, pick first set bit scanning rr_ptr, rr_ptr+1, … mod NUM_PORTS; register grant_idx, go BUSY, pulse port_req_ack[grant].
- BUSY: mem_req_valid=1; addr/opcode/store_data muxed from ports by registered grant_idx. Requester holds its fields stable from valid until its rsp.
- BUSY & mem_rsp_valid: port_rsp_valid[grant_idx]=1 same cycle (combinational), go IDLE, rr_ptr ← (grant_idx+1) mod NUM_PORTS.
- mem_rsp_valid in IDLE ignored.
- Same port re-requesting while BUSY: pending sets; served in later round-robin turn.
- Watchdog: counter clears on entering BUSY, increments each BUSY cycle, saturates; reaching TIMEOUT_CYCLES sets timeout_err (cleared only by reset); transaction keeps waiting.
- NUM_PORTS=1: rr_ptr stays 0.

## Timing
- Reset values: mem_req_valid=0, busy=0, port_req_ack=0, port_rsp_valid=0, grant_idx=0, rr_ptr=0, pending=0, timeout_err=0, state IDLE; mem_req_* data outputs reflect port 0 mux.
- Request pulse at cycle t, arbiter IDLE: port_req_ack and mem_req_valid high at t+1.
- mem_rsp_valid at cycle r: port_rsp_valid at r; mem_req_valid low at r+1; next grant (if pending) mem_req_valid at r+2 (one idle gap).
- Simultaneous requests: one grant per transaction, strict rotation from rr_ptr.
- Reset asserted mid-transaction: all state clears immediately; late mem_rsp_valid after release ignored.

## Structure
- Shared package (mem_arb_pkg): arb_state_t enum, opcode constants shared with l1d/l1i.
- Sub-module rr_pick: combinational rotating priority encoder (req vector, ptr → one-hot grant, index, any).

## Test plan
- NUM_PORTS=2, port 1 pulses addr 0x1000 alone → ack[1] and mem_req_valid at t+1, addr=0x1000; rsp at t+5 → port_rsp_valid=2'b10 at t+5, mem_req_valid low t+6.
- NUM_PORTS=4, all ports pulse same cycle, rsp 3 cycles after each grant → grant order 0,1,2,3, each with own addr/store data.
- Port 2 granted, port 0 and 3 pulse during BUSY → after rsp, next grant port 3 then port 0.
- TIMEOUT_CYCLES=8, no rsp → timeout_err rises after 8 BUSY cycles, stays high after late rsp until reset.
- Reset asserted 2 cycles into BUSY → mem_req_valid, busy, pending drop immediately; rsp pulse after release produces no port_rsp_valid.
- NUM_PORTS=1, back-to-back pulses → transactions serialized with one-cycle gap, grant_idx=0.
